button_scanner: RTL and testbench

BUTTON_SCANNER -- requirements
Module: button_scanner

---
 rtl/button_scanner.sv | 181 ++++++++++++++++++
 tb/tb_button_scanner.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_scanner.sv
// button_scanner: N-channel switch debouncer with a time-multiplexed scan FSM.
// Each sample tick captures a snapshot of the synchronized inputs. One channel
// per cycle then shifts its 8-sample history, and press/release events go into
// a small FIFO. A sticky overflow flag is set when an event is dropped.
module button_scanner #(
    parameter int N          = 4,
    parameter int DIV        = 50_000_000 / 50 / 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N-1:0]         noisy,
    output logic [N-1:0]         clean,
    output logic                 ev_valid,
    input  logic                 ev_ready,
    output logic [$clog2(N)-1:0] ev_chan,
    output logic                 ev_rise,
    output logic                 ovf,
    input  logic                 ovf_clr,
    output logic                 busy
);
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(DIV);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int EV_W  = IDX_W + 1;

    // A scan needs N cycles plus settling, so a tick can never land mid-scan.
    if (N < 2 || N > 16) begin : g_bad_n
        $error("button_scanner: N must be in 2..16");
    end
    if (DIV < N + 2) begin : g_bad_div
        $error("button_scanner: DIV must be at least N+2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("button_scanner: FIFO_DEPTH must be a power of 2, at least 2");
    end

    typedef enum logic {IDLE, SCAN} state_t;

    logic [N-1:0]     sync1_q, sync1_d, sync2_q, sync2_d;
    logic [N-1:0]     snap_q, snap_d, clean_q, clean_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             tick;
    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       hist_q [N];
    logic [7:0]       hist_d [N];
    logic [7:0]       hist_upd;
    logic             busy_q, busy_d;
    logic             push;
    logic [EV_W-1:0]  push_ev;
    logic [EV_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             pop, full, accept, drop;

    // Sample-tick divider (frozen while en=0), input synchronizer and tick snapshot
    always_comb begin
        tick    = en && (div_q == CNT_W'(DIV - 1));
        div_d   = div_q;
        if (en) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end
        sync1_d = noisy;
        sync2_d = sync1_q;
        snap_d  = tick ? sync2_q : snap_q;
    end

    // Scan FSM: visit one channel per cycle, update its history, raise events
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hist_d   = hist_q;
        clean_d  = clean_q;
        push     = 1'b0;
        push_ev  = {idx_q, 1'b0};
        hist_upd = {hist_q[idx_q][6:0], snap_q[idx_q]};
        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                hist_d[idx_q] = hist_upd;
                if (hist_upd == 8'hFF && !clean_q[idx_q]) begin
                    clean_d[idx_q] = 1'b1;
                    push           = 1'b1;
                    push_ev        = {idx_q, 1'b1};
                end else if (hist_upd == 8'h00 && clean_q[idx_q]) begin
                    clean_d[idx_q] = 1'b0;
                    push           = 1'b1;
                    push_ev        = {idx_q, 1'b0};
                end
                if (idx_q == IDX_W'(N - 1)) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
        busy_d = (state_d == SCAN);
    end

    // Event FIFO control: a pop in the same cycle frees room for a push into a full queue
    always_comb begin
        pop    = (cnt_q != '0) && ev_ready;
        full   = (cnt_q == (PTR_W + 1)'(FIFO_DEPTH));
        accept = push && (!full || pop);
        drop   = push && full && !pop;
        wr_d   = accept ? wr_q + 1'b1 : wr_q;
        rd_d   = pop ? rd_q + 1'b1 : rd_q;
        cnt_d  = cnt_q;
        if (accept && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!accept && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // State registers; reset discards pending events and any partial scan
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            snap_q  <= '0;
            clean_q <= '0;
            div_q   <= '0;
            state_q <= IDLE;
            idx_q   <= '0;
            hist_q  <= '{default: 8'h00};
            busy_q  <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            snap_q  <= snap_d;
            clean_q <= clean_d;
            div_q   <= div_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            hist_q  <= hist_d;
            busy_q  <= busy_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Event storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_q] <= push_ev;
        end
    end

    assign clean              = clean_q;
    assign ev_valid           = (cnt_q != '0);
    assign {ev_chan, ev_rise} = mem_q[rd_q];
    assign ovf                = ovf_q;
    assign busy               = busy_q;

endmodule

// File: tb/tb_button_scanner.sv
// tb_button_scanner: directed stimulus with a behavioural run-length model of
// the debouncer and an event queue, compared against the DUT every cycle.
module tb_button_scanner;
    localparam int N     = 4;
    localparam int DIV   = 10;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [3:0] noisy = 4'b0000;
    logic [3:0] clean;
    logic       ev_valid;
    logic       ev_ready = 1'b0;
    logic [1:0] ev_chan;
    logic       ev_rise;
    logic       ovf;
    logic       ovf_clr = 1'b0;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit started = 0;

    // Model state: synchronizer stages, snapshot, per-channel run of equal samples
    logic [3:0] m_s1, m_s2, m_snap, m_clean;
    int         m_cnt, m_pos;
    bit         m_last [4];
    int         m_run [4];
    int         m_q [$];
    bit         m_ovf;

    button_scanner #(.N(N), .DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en), .noisy(noisy), .clean(clean),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_chan(ev_chan),
        .ev_rise(ev_rise), .ovf(ovf), .ovf_clr(ovf_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin : cycle_counter
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t, cyc=%0d)", name, act, exp, $time, cyc);
        end
    endtask

    function automatic void m_reset();
        m_s1 = '0; m_s2 = '0; m_snap = '0; m_clean = '0;
        m_cnt = 0; m_pos = -1; m_ovf = 0;
        m_q.delete();
        for (int k = 0; k < N; k++) begin
            m_last[k] = 0;
            m_run[k]  = 8;
        end
    endfunction

    // One clock of the model: a level counts as settled once 8 equal samples are seen
    function automatic void m_step();
        bit do_pop, do_push, dropped, tk;
        int ev, k;
        do_pop  = (m_q.size() != 0) && ev_ready;
        do_push = 0;
        dropped = 0;
        ev      = 0;
        if (m_pos >= 0) begin
            k = m_pos;
            if (m_snap[k] == m_last[k]) begin
                if (m_run[k] < 8) m_run[k]++;
            end else begin
                m_last[k] = m_snap[k];
                m_run[k]  = 1;
            end
            if (m_run[k] >= 8 && m_last[k] != m_clean[k]) begin
                m_clean[k] = m_last[k];
                do_push    = 1;
                ev         = k * 2 + (m_last[k] ? 1 : 0);
            end
        end
        tk = en && (m_cnt == DIV - 1);
        if (en) m_cnt = (m_cnt + 1) % DIV;
        if (m_pos == N - 1) m_pos = -1;
        else if (m_pos >= 0) m_pos++;
        else if (tk) m_pos = 0;
        if (tk) m_snap = m_s2;
        m_s2 = m_s1;
        m_s1 = noisy;
        if (do_pop) void'(m_q.pop_front());
        if (do_push) begin
            if (m_q.size() < DEPTH) m_q.push_back(ev);
            else dropped = 1;
        end
        if (dropped) m_ovf = 1;
        else if (ovf_clr) m_ovf = 0;
    endfunction

    initial begin : model
        m_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) m_reset();
            else m_step();
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (started) begin
                check("clean", 32'(clean), 32'(m_clean));
                check("ev_valid", 32'(ev_valid), 32'(m_q.size() != 0));
                if (m_q.size() != 0) begin
                    check("ev_chan", 32'(ev_chan), 32'(m_q[0] / 2));
                    check("ev_rise", 32'(ev_rise), 32'(m_q[0] % 2));
                end
                check("ovf", 32'(ovf), 32'(m_ovf));
                check("busy", 32'(busy), 32'(m_pos >= 0));
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 0; en = 0; noisy = '0; ev_ready = 0; ovf_clr = 0;
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic release_rst(input logic [3:0] nz, input logic e);
        noisy = nz;
        en    = e;
        rst   = 1;
        cyc   = 0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n - cyc) @(posedge clk);
        #2;
    endtask

    task automatic pop_expect(input int ch, input int rs);
        check("pop_valid", 32'(ev_valid), 32'd1);
        check("pop_chan", 32'(ev_chan), 32'(ch));
        check("pop_rise", 32'(ev_rise), 32'(rs));
        ev_ready = 1;
        @(posedge clk); #2;
        ev_ready = 0;
    endtask

    initial begin : stimulus
        repeat (2) @(posedge clk);
        #2;
        started = 1;
        // reset state
        check("rst_clean", 32'(clean), 32'd0);
        check("rst_ev_valid", 32'(ev_valid), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // single channel held high: press lands on the 8th tick's scan (edge 83)
        do_reset();
        release_rst(4'b0100, 1'b1);
        wait_cyc(82);
        check("t36_clean_before", 32'(clean), 32'd0);
        check("t36_valid_before", 32'(ev_valid), 32'd0);
        wait_cyc(83);
        check("t36_clean_after", 32'(clean), 32'b0100);
        pop_expect(2, 1);
        wait_cyc(200);
        check("t36_no_more_ev", 32'(ev_valid), 32'd0);
        check("t36_clean_final", 32'(clean), 32'b0100);

        // channel toggling every tick never settles
        do_reset();
        release_rst(4'b0010, 1'b1);
        for (int i = 0; i < 19; i++) begin
            wait_cyc(10 * i + 5);
            noisy[1] = ~noisy[1];
        end
        wait_cyc(300);
        check("t37_clean", 32'(clean), 32'd0);
        check("t37_no_ev", 32'(ev_valid), 32'd0);

        // four presses fill the queue; a release is dropped even with ovf_clr high
        do_reset();
        release_rst(4'b1111, 1'b1);
        wait_cyc(85);
        check("t38_clean", 32'(clean), 32'b1111);
        check("t38_head_chan", 32'(ev_chan), 32'd0);
        check("t38_ovf0", 32'(ovf), 32'd0);
        wait_cyc(90);
        noisy = 4'b1110;
        wait_cyc(170);
        check("t38_ovf_pre", 32'(ovf), 32'd0);
        ovf_clr = 1;
        wait_cyc(171);
        ovf_clr = 0;
        check("t38_ovf_set", 32'(ovf), 32'd1);
        check("t38_clean_rel", 32'(clean), 32'b1110);
        ovf_clr = 1;
        wait_cyc(172);
        ovf_clr = 0;
        check("t38_ovf_clr", 32'(ovf), 32'd0);
        pop_expect(0, 1);
        pop_expect(1, 1);
        pop_expect(2, 1);
        pop_expect(3, 1);
        check("t38_empty", 32'(ev_valid), 32'd0);

        // full queue with a pop in the push cycle: nothing dropped
        do_reset();
        release_rst(4'b1111, 1'b1);
        wait_cyc(90);
        noisy = 4'b1110;
        wait_cyc(170);
        check("t39_head0", 32'(ev_chan), 32'd0);
        ev_ready = 1;
        wait_cyc(171);
        ev_ready = 0;
        check("t39_ovf", 32'(ovf), 32'd0);
        check("t39_head1", 32'(ev_chan), 32'd1);
        pop_expect(1, 1);
        pop_expect(2, 1);
        pop_expect(3, 1);
        pop_expect(0, 0);
        check("t39_empty", 32'(ev_valid), 32'd0);

        // reset mid-scan with two events queued
        do_reset();
        release_rst(4'b0011, 1'b1);
        wait_cyc(82);
        check("t40_busy", 32'(busy), 32'd1);
        check("t40_valid", 32'(ev_valid), 32'd1);
        rst = 0;
        #1;
        check("t40_rst_valid", 32'(ev_valid), 32'd0);
        check("t40_rst_clean", 32'(clean), 32'd0);
        check("t40_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        release_rst(4'b0011, 1'b1);
        wait_cyc(85);
        check("t40_resume_clean", 32'(clean), 32'b0011);
        pop_expect(0, 1);
        pop_expect(1, 1);

        // en dropped for 50 cycles between ticks 4 and 5
        do_reset();
        release_rst(4'b1000, 1'b1);
        wait_cyc(45);
        en = 0;
        wait_cyc(95);
        en = 1;
        wait_cyc(133);
        check("t41_clean_before", 32'(clean), 32'd0);
        wait_cyc(134);
        check("t41_clean_after", 32'(clean), 32'b1000);
        pop_expect(3, 1);
        wait_cyc(220);
        check("t41_no_more_ev", 32'(ev_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
